// File: rtl/fixed_multiply_pipe.sv
// fixed_multiply_pipe
// Pipelined signed fixed-point multiplier for the streaming sample path.
// The full-width product is rescaled to the operand Q format, with optional
// round-half-up and optional saturation. o_overflow reports when the rescaled
// product does not fit in operand_size bits.
//
// Ports:
//   i_clk       clock
//   i_rst       synchronous active-high reset
//   i_valid     input sample valid
//   o_ready     input can be accepted this cycle
//   i_a, i_b    signed operands, Q(operand_size-fractional_size).fractional_size
//   o_valid     o_res / o_overflow valid
//   i_ready     downstream accepts output this cycle
//   o_res       scaled product in operand format
//   o_overflow  result exceeded the representable range
//
// Pipeline mapping: with pipeline_depth >= 2 the raw product is registered
// first and rescaling happens into the next stage. The remaining stages are
// plain delay registers. With pipeline_depth == 1 everything is combinational
// into the single output register.
module fixed_multiply_pipe #(
    parameter int fractional_size = 12,
    parameter int operand_size    = 32,
    parameter int pipeline_depth  = 3,
    parameter bit round_mode      = 1'b1,
    parameter bit saturate        = 1'b1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [operand_size-1:0] i_a,
    input  logic [operand_size-1:0] i_b,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [operand_size-1:0] o_res,
    output logic                    o_overflow
);

    localparam int PW = 2 * operand_size;
    // number of result-carrying stages (the product stage is separate)
    localparam int DS = (pipeline_depth > 1) ? pipeline_depth - 1 : 1;
    localparam logic signed [PW:0] HALF = (PW+1)'(1) << (fractional_size - 1);

    // Returns {overflow, result}. The rounding add is one bit wider than the
    // product so it cannot wrap.
    function automatic logic [operand_size:0] f_scale(input logic signed [PW-1:0] p);
        logic signed [PW:0]        v_p;
        logic signed [PW:0]        v_r;
        logic                      v_ovf;
        logic [operand_size-1:0]   v_res;
        v_p = {p[PW-1], p};
        if (round_mode)
            v_p = v_p + HALF;
        v_r = v_p >>> fractional_size;
        // fits only if every bit above the result sign bit equals the sign
        v_ovf = !((&v_r[PW:operand_size-1]) || !(|v_r[PW:operand_size-1]));
        if (saturate && v_ovf)
            v_res = v_r[PW] ? {1'b1, {(operand_size-1){1'b0}}}
                            : {1'b0, {(operand_size-1){1'b1}}};
        else
            v_res = v_r[operand_size-1:0];
        return {v_ovf, v_res};
    endfunction

    logic signed [PW-1:0]      w_a_ext;
    logic signed [PW-1:0]      w_b_ext;
    logic signed [PW-1:0]      w_prod;
    logic [operand_size:0]     w_scaled;
    logic                      w_advance;
    logic                      w_accept;

    logic [pipeline_depth-1:0] r_vld;
    logic [operand_size-1:0]   r_res [DS];
    logic [DS-1:0]             r_ovf;

    assign w_a_ext   = {{operand_size{i_a[operand_size-1]}}, i_a};
    assign w_b_ext   = {{operand_size{i_b[operand_size-1]}}, i_b};
    assign w_prod    = w_a_ext * w_b_ext;

    assign w_advance = !o_valid || i_ready;
    assign o_ready   = w_advance && !i_rst;
    assign w_accept  = i_valid && o_ready;

    generate
        if (pipeline_depth == 1) begin : g_comb
            assign w_scaled = f_scale(w_prod);
        end else begin : g_prod
            logic signed [PW-1:0] r_prod;
            always_ff @(posedge i_clk) begin
                if (i_rst)
                    r_prod <= '0;
                else if (w_advance)
                    r_prod <= w_prod;
            end
            assign w_scaled = f_scale(r_prod);
        end
    endgenerate

    // r_vld[0] tracks the first stage; the last result stage lines up with
    // r_vld[pipeline_depth-1]. Bubbles shift along like real samples.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld <= '0;
            r_ovf <= '0;
            for (int i = 0; i < DS; i++)
                r_res[i] <= '0;
        end else if (w_advance) begin
            r_vld[0] <= w_accept;
            for (int i = 1; i < pipeline_depth; i++)
                r_vld[i] <= r_vld[i-1];
            r_res[0] <= w_scaled[operand_size-1:0];
            r_ovf[0] <= w_scaled[operand_size];
            for (int i = 1; i < DS; i++) begin
                r_res[i] <= r_res[i-1];
                r_ovf[i] <= r_ovf[i-1];
            end
        end
    end

    assign o_valid    = r_vld[pipeline_depth-1];
    assign o_res      = r_res[DS-1];
    assign o_overflow = r_ovf[DS-1];

endmodule

// File: doc/fixed_multiply_pipe.md
Name: fixed_multiply_pipe

Overview:
Pipelined signed fixed-point multiplier. It is the successor to the combinational full-width multiplier used in the audio effect chain.
- Returns a result already scaled back to operand format, with selectable rounding and saturation and an overflow flag.
- Uses a valid/ready handshake with backpressure, so it can sit directly in a streaming sample path between effect stages.

Parameters:
fractional_size, 12, number of fractional bits in both operands and in the result; legal range 1 .. operand_size-1
operand_size, 32, width of i_a, i_b and o_res (two's complement)
pipeline_depth, 3, register stages from input acceptance to o_valid; legal range 1..6
round_mode, 1, 0 = truncate (floor), 1 = round half up (add 2^(fractional_size-1) before shift)
saturate, 1, 1 = clamp to operand range on overflow, 0 = wrap (keep low operand_size bits)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, synchronous, active-high
i_valid  in  1  input sample valid
o_ready  out  1  block can accept input this cycle
i_a  in  operand_size  multiplicand, signed Q(operand_size-fractional_size).fractional_size
i_b  in  operand_size  multiplier, same format
o_valid  out  1  o_res/o_overflow valid
i_ready  in  1  downstream accepts output this cycle
o_res  out  operand_size  scaled product, same Q format as operands
o_overflow  out  1  result exceeded representable range (clamped if saturate=1, wrapped if 0)

Behaviour:
- Single clock domain. i_rst is sampled on the i_clk rising edge only, active-high.
- Reset values: all internal valid bits 0; o_valid=0; o_res=0; o_overflow=0. o_ready is forced 0 while i_rst=1.
- Reset mid-stream discards every in-flight sample. No output appears for samples accepted before reset.
- Arithmetic:
  - p = signed(i_a) * signed(i_b), full 2*operand_size bits.
  - If round_mode=1: p += 2^(fractional_size-1).
  - r = p >>> fractional_size (arithmetic shift).
  - Overflow when r > 2^(operand_size-1)-1 or r < -2^(operand_size-1).
  - saturate=1: o_res = max/min positive/negative value on overflow, else r[operand_size-1:0].
  - saturate=0: o_res = r[operand_size-1:0] always.
  - o_overflow set in both modes.
  - Rounding addition is done at 2*operand_size+1 bits, so it never wraps internally.
- Pipeline control:
  - advance = !o_valid || i_ready.
  - o_ready = advance && !i_rst.
  - Accept occurs when i_valid && o_ready.
  - On advance, every stage shifts one place. The stage-0 valid bit loads (i_valid && o_ready).
  - When advance=0, all stages hold. o_res/o_overflow/o_valid remain stable until accepted.
- Latency: exactly pipeline_depth cycles from acceptance to o_valid=1 when i_ready is held 1. Throughput is 1 sample/cycle.
- Bubbles are not collapsed. Idle stages still advance only under the global enable. Order is strictly preserved; no sample is dropped or duplicated.
- Simultaneous accept and output handshake in one cycle is legal and is the steady-state case.
- Multiplier mapping (split across the first stages) is free, provided latency and results are exact.
- Data registers of invalid stages may hold any value. o_res is don't-care while o_valid=0, except the reset value 0.

Test Plan:
- Default params, i_ready=1, a=0x00001800 (1.5), b=0x00002000 (2.0), one-cycle i_valid → o_valid pulses exactly 3 cycles later, o_res=0x00003000, o_overflow=0.
- Rounding, a=0x00000001, b=0x00000800:
  - round_mode=1 → o_res=0x00000001.
  - round_mode=0 → o_res=0x00000000.
  - round_mode=1 with a=0xFFFFFFFF, same b → o_res=0x00000000 (half rounds up).
- Saturation, a=b=0x7FFFFFFF:
  - saturate=1 → o_res=0x7FFFFFFF, o_overflow=1.
  - a=0x80000000, b=0x7FFFFFFF → o_res=0x80000000, o_overflow=1.
  - saturate=0 → o_res = low 32 bits of the shifted product, o_overflow=1.
- Backpressure: stream 10 back-to-back samples (a=k·0x1000, b=0x1000, k=1..10) while i_ready is low on cycles 4-8.
  - o_ready=0 whenever o_valid && !i_ready.
  - o_res is held stable during the stall.
  - Outputs are k·0x1000 in order, with none lost or duplicated.
- Reset mid-operation: accept 2 samples, assert i_rst 1 cycle after the second → o_valid=0, o_res=0 the next cycle, no stale outputs ever appear, and o_ready=1 the first cycle after i_rst falls.
- Depth sweep: pipeline_depth=1 and 6 with the first scenario → latency 1 and 6 cycles respectively, same o_res.
